// File: rtl/ysyx_22051013_cache_tag_array_pkg.sv
// Shared cache geometry defaults and tag-array sweep FSM encodings.
package ysyx_22051013_cache_tag_array_pkg;

  localparam int WAYS_DEF  = 2;
  localparam int SETS_DEF  = 32;
  localparam int TAG_W_DEF = 24;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/ysyx_22051013_cache_tag_array_if.sv
// Lookup / fill / flush port bundle between the cache FSM (master) and the tag array (slave).
interface ysyx_22051013_cache_tag_array_if
  import ysyx_22051013_cache_tag_array_pkg::*;
#(
  parameter int WAYS  = WAYS_DEF,
  parameter int SETS  = SETS_DEF,
  parameter int TAG_W = TAG_W_DEF
);
  localparam int IDX_W = $clog2(SETS);

  logic                  rd_en;
  logic [IDX_W-1:0]      rd_idx;
  logic [TAG_W-1:0]      rd_tag;
  logic                  rd_hit;
  logic [WAYS-1:0]       rd_hit_way;
  logic [WAYS*TAG_W-1:0] rd_tags;
  logic [WAYS-1:0]       rd_valid;
  logic [WAYS-1:0]       rd_dirty;
  logic [WAYS-1:0]       rd_victim;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [WAYS-1:0]       wr_way;
  logic [TAG_W-1:0]      wr_tag;
  logic                  wr_valid;
  logic                  wr_dirty;
  logic                  flush;
  logic                  busy;

  modport master (
    output rd_en, rd_idx, rd_tag, wr_en, wr_idx, wr_way, wr_tag, wr_valid, wr_dirty, flush,
    input  rd_hit, rd_hit_way, rd_tags, rd_valid, rd_dirty, rd_victim, busy
  );

  modport slave (
    input  rd_en, rd_idx, rd_tag, wr_en, wr_idx, wr_way, wr_tag, wr_valid, wr_dirty, flush,
    output rd_hit, rd_hit_way, rd_tags, rd_valid, rd_dirty, rd_victim, busy
  );

endinterface

// File: rtl/ysyx_22051013_tag_way_ram.sv
// One tag way: SETS x W synchronous-read RAM, read-first on same-address write.
// Read data changes only on re; no reset, contents are initialised by the owner's sweep.
module ysyx_22051013_tag_way_ram #(
  parameter int SETS = 32,
  parameter int W    = 26,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [W-1:0]     rdata
);
  logic [W-1:0] mem [SETS];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ysyx_22051013_cache_tag_array.sv
// Set-associative tag store with hit detect, victim suggestion and invalidate-all sweep.
// Lookup result appears two edges after rd_en is sampled; all requests are dropped while busy.
module ysyx_22051013_cache_tag_array
  import ysyx_22051013_cache_tag_array_pkg::*;
#(
  parameter int WAYS  = WAYS_DEF,
  parameter int SETS  = SETS_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input logic clk,
  input logic rst_n,
  ysyx_22051013_cache_tag_array_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int ENT_W = TAG_W + 2;
  localparam int RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             sweep, rd_acc, wr_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(SETS - 1)) state_d = IDLE;
      end
      default: begin
        if (bus.flush) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Flush beats a same-cycle write; nothing is accepted during the sweep.
  always_comb begin
    sweep  = (state_q == SWEEP);
    rd_acc = !sweep && bus.rd_en;
    wr_acc = !sweep && bus.wr_en && !bus.flush;
  end

  logic [ENT_W-1:0] way_rdata [WAYS];
  logic [ENT_W-1:0] way_wdata;
  logic [IDX_W-1:0] way_waddr;

  assign way_wdata = sweep ? '0 : {bus.wr_valid, bus.wr_dirty, bus.wr_tag};
  assign way_waddr = sweep ? cnt_q : bus.wr_idx;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    ysyx_22051013_tag_way_ram #(.SETS(SETS), .W(ENT_W)) u_ram (
      .clk   (clk),
      .we    (sweep || (wr_acc && bus.wr_way[w])),
      .waddr (way_waddr),
      .wdata (way_wdata),
      .re    (rd_acc),
      .raddr (bus.rd_idx),
      .rdata (way_rdata[w])
    );
  end

  logic                  rd_pend_q, rd_pend_d;
  logic [TAG_W-1:0]      rd_tag_q, rd_tag_d;
  logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
  logic [RR_W-1:0]       rr_q [SETS];
  logic [RR_W-1:0]       rr_d [SETS];
  logic                  rd_hit_q, rd_hit_d;
  logic [WAYS-1:0]       rd_hit_way_q, rd_hit_way_d;
  logic [WAYS*TAG_W-1:0] rd_tags_q, rd_tags_d;
  logic [WAYS-1:0]       rd_valid_q, rd_valid_d;
  logic [WAYS-1:0]       rd_dirty_q, rd_dirty_d;
  logic [WAYS-1:0]       rd_victim_q, rd_victim_d;
  logic [WAYS-1:0]       hit_way, way_vld, way_drt, victim;
  logic [WAYS*TAG_W-1:0] way_tags;

  always_comb begin
    hit_way  = '0;
    way_vld  = '0;
    way_drt  = '0;
    way_tags = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_tags[w*TAG_W +: TAG_W] = way_rdata[w][TAG_W-1:0];
      way_vld[w] = way_rdata[w][TAG_W+1];
      way_drt[w] = way_rdata[w][TAG_W];
      hit_way[w] = way_rdata[w][TAG_W+1] && (way_rdata[w][TAG_W-1:0] == rd_tag_q);
    end
  end

  // Lowest invalid way first; round-robin only once the set is full.
  always_comb begin
    victim = WAYS'(1) << rr_q[rd_idx_q];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_vld[w]) victim = WAYS'(1) << w;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (sweep) begin
      rr_d[cnt_q] = '0;
    end else if (WAYS > 1 && wr_acc && bus.wr_valid && bus.wr_way[rr_q[bus.wr_idx]]) begin
      rr_d[bus.wr_idx] = rr_q[bus.wr_idx] + 1'b1;
    end
  end

  always_comb begin
    rd_pend_d    = rd_acc;
    rd_tag_d     = rd_acc ? bus.rd_tag : rd_tag_q;
    rd_idx_d     = rd_acc ? bus.rd_idx : rd_idx_q;
    rd_hit_d     = rd_hit_q;
    rd_hit_way_d = rd_hit_way_q;
    rd_tags_d    = rd_tags_q;
    rd_valid_d   = rd_valid_q;
    rd_dirty_d   = rd_dirty_q;
    rd_victim_d  = rd_victim_q;
    if (rd_pend_q) begin
      rd_hit_d     = |hit_way;
      rd_hit_way_d = hit_way;
      rd_tags_d    = way_tags;
      rd_valid_d   = way_vld;
      rd_dirty_d   = way_drt;
      rd_victim_d  = victim;
    end
    // A held hit would be stale once the sweep starts clearing the sets.
    if (sweep) begin
      rd_hit_d     = 1'b0;
      rd_hit_way_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend_q    <= 1'b0;
      rd_tag_q     <= '0;
      rd_idx_q     <= '0;
      rr_q         <= '{default: '0};
      rd_hit_q     <= 1'b0;
      rd_hit_way_q <= '0;
      rd_tags_q    <= '0;
      rd_valid_q   <= '0;
      rd_dirty_q   <= '0;
      rd_victim_q  <= '0;
    end else begin
      rd_pend_q    <= rd_pend_d;
      rd_tag_q     <= rd_tag_d;
      rd_idx_q     <= rd_idx_d;
      rr_q         <= rr_d;
      rd_hit_q     <= rd_hit_d;
      rd_hit_way_q <= rd_hit_way_d;
      rd_tags_q    <= rd_tags_d;
      rd_valid_q   <= rd_valid_d;
      rd_dirty_q   <= rd_dirty_d;
      rd_victim_q  <= rd_victim_d;
    end
  end

  assign bus.busy       = sweep;
  assign bus.rd_hit     = rd_hit_q && !sweep;
  assign bus.rd_hit_way = rd_hit_way_q;
  assign bus.rd_tags    = rd_tags_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_dirty   = rd_dirty_q;
  assign bus.rd_victim  = rd_victim_q;

endmodule
